// File: rtl/fp_div_operand_loader.sv
// rtl/fp_div_operand_loader.sv - byte-serial operand loader / result unloader wrapped around fp_division
// Optional special-operand override of the quotient is compiled in with FP_DIV_SPECIAL_CASE_EN.
module fp_div_operand_loader #(
  parameter int DIV_LATENCY = 2,
  parameter bit LSB_FIRST   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_in,
  input  logic        byte_vld,
  output logic        byte_rdy,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  input  logic [31:0] div_c,
  output logic [7:0]  byte_out,
  output logic        byte_out_vld,
  input  logic        byte_out_rdy,
  output logic        busy,
  output logic        done,
  output logic [2:0]  exc
);

  localparam int LW = (DIV_LATENCY < 1) ? 1 : $clog2(DIV_LATENCY + 1);

  typedef enum logic [1:0] {S_LOAD_A, S_LOAD_B, S_WAIT, S_SEND} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [31:0]   div_a_q, div_a_d;
  logic [31:0]   div_b_q, div_b_d;
  logic [31:0]   res_q, res_d, res_sel;
  logic [2:0]    exc_q, exc_d, exc_sel;
  logic          done_q, done_d;
  logic [1:0]    lane;
  logic [4:0]    lane_lsb;

  // The byte counter walks lanes in transfer order; lane is the byte position inside the word.
  assign lane     = LSB_FIRST ? cnt_q : (2'd3 - cnt_q);
  assign lane_lsb = {lane, 3'b000};

`ifdef FP_DIV_SPECIAL_CASE_EN
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, q_sign;

  always_comb begin
    a_zero  = (div_a_q[30:23] == 8'h00);
    a_inf   = (div_a_q[30:23] == 8'hFF) && (div_a_q[22:0] == 23'd0);
    a_nan   = (div_a_q[30:23] == 8'hFF) && (div_a_q[22:0] != 23'd0);
    b_zero  = (div_b_q[30:23] == 8'h00);
    b_inf   = (div_b_q[30:23] == 8'hFF) && (div_b_q[22:0] == 23'd0);
    b_nan   = (div_b_q[30:23] == 8'hFF) && (div_b_q[22:0] != 23'd0);
    q_sign  = div_a_q[31] ^ div_b_q[31];
    res_sel = div_c;
    exc_sel = 3'b000;
    // Earlier branches exclude the indeterminate forms, so later ones need no extra qualifiers.
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      res_sel = 32'h7FC0_0000;
      exc_sel = 3'b100;
    end else if (b_zero || a_inf) begin
      res_sel = {q_sign, 8'hFF, 23'd0};
      exc_sel = 3'b010;
    end else if (a_zero || b_inf) begin
      res_sel = {q_sign, 8'h00, 23'd0};
      exc_sel = 3'b001;
    end
  end
`else
  assign res_sel = div_c;
  assign exc_sel = 3'b000;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_LOAD_A;
      cnt_q   <= 2'd0;
      lat_q   <= '0;
      div_a_q <= 32'd0;
      div_b_q <= 32'd0;
      res_q   <= 32'd0;
      exc_q   <= 3'b000;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lat_d        = lat_q;
    div_a_d      = div_a_q;
    div_b_d      = div_b_q;
    res_d        = res_q;
    exc_d        = exc_q;
    done_d       = 1'b0;
    byte_rdy     = 1'b0;
    byte_out_vld = 1'b0;
    byte_out     = 8'h00;
    busy         = 1'b0;
    case (state_q)
      S_LOAD_A: begin
        byte_rdy = 1'b1;
        if (byte_vld) begin
          div_a_d[lane_lsb +: 8] = byte_in;
          cnt_d                  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        byte_rdy = 1'b1;
        if (byte_vld) begin
          div_b_d[lane_lsb +: 8] = byte_in;
          cnt_d                  = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_WAIT;
            lat_d   = '0;
          end
        end
      end
      S_WAIT: begin
        busy  = 1'b1;
        lat_d = lat_q + LW'(1);
        // One edge beyond the divider pipeline depth covers its combinational divide path.
        if (lat_q == LW'(DIV_LATENCY)) begin
          res_d   = res_sel;
          exc_d   = exc_sel;
          cnt_d   = 2'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        busy         = 1'b1;
        byte_out_vld = 1'b1;
        byte_out     = res_q[lane_lsb +: 8];
        if (byte_out_rdy) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = S_LOAD_A;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_LOAD_A;
    endcase
  end

  assign div_a = div_a_q;
  assign div_b = div_b_q;
  assign done  = done_q;
  assign exc   = exc_q;

endmodule

// File: tb/tb_fp_div_operand_loader.sv
// tb/tb_fp_div_operand_loader.sv - scoreboard bench driving an MSB-first and an LSB-first loader in lockstep
// Each loader feeds a bench model of the 2-stage fp_division; FP_DIV_SPECIAL_CASE_EN selects the expected override rules.
module tb_fp_div_operand_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, byte_vld, byte_out_rdy;
  logic [7:0]  byte_in0, byte_in1, byte_out0, byte_out1;
  logic        byte_rdy0, byte_rdy1, byte_out_vld0, byte_out_vld1;
  logic        busy0, busy1, done0, done1;
  logic [2:0]  exc0, exc1;
  logic [31:0] div_a0, div_b0, div_c0, div_a1, div_b1, div_c1;
  logic [31:0] a1_0, b1_0, a1_1, b1_1;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  q_exp0[$];
  logic [7:0]  q_exp1[$];
  logic [2:0]  q_exc0[$];
  logic [2:0]  q_exc1[$];
  int          nbytes[2];
  logic        hold_vld[2];
  logic [7:0]  hold_byte[2];
  int          rdy_mode;
  int          stall_cnt;

`ifdef FP_DIV_SPECIAL_CASE_EN
  localparam logic [2:0] EXC_DIV0 = 3'b010;
`else
  localparam logic [2:0] EXC_DIV0 = 3'b000;
`endif

  fp_div_operand_loader #(.DIV_LATENCY(2), .LSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in0), .byte_vld(byte_vld), .byte_rdy(byte_rdy0),
    .div_a(div_a0), .div_b(div_b0), .div_c(div_c0), .byte_out(byte_out0),
    .byte_out_vld(byte_out_vld0), .byte_out_rdy(byte_out_rdy), .busy(busy0), .done(done0), .exc(exc0)
  );

  fp_div_operand_loader #(.DIV_LATENCY(2), .LSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in1), .byte_vld(byte_vld), .byte_rdy(byte_rdy1),
    .div_a(div_a1), .div_b(div_b1), .div_c(div_c1), .byte_out(byte_out1),
    .byte_out_vld(byte_out_vld1), .byte_out_rdy(byte_out_rdy), .busy(busy1), .done(done1), .exc(exc1)
  );

  function automatic real s2r(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    e = {3'b000, x[30:23]} + 11'd896;
    if (x[30:23] == 8'h00)      d = {x[31], 63'd0};
    else if (x[30:23] == 8'hFF) d = {x[31], 11'h7FF, (x[22:0] != 23'd0), 51'd0};
    else                        d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    int          e;
    d = $realtobits(r);
    e = int'({21'd0, d[62:52]}) - 896;
    if (d[62:52] == 11'd0 || e <= 0) return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] sp_div(input logic [31:0] a, input logic [31:0] b);
    return r2s(s2r(a) / s2r(b));
  endfunction

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic [2:0] x);
`ifdef FP_DIV_SPECIAL_CASE_EN
    bit az, ai, an, bz, bi, bn, s;
    az = (a[30:23] == 8'h00); ai = (a[30:23] == 8'hFF) && (a[22:0] == 0); an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bz = (b[30:23] == 8'h00); bi = (b[30:23] == 8'hFF) && (b[22:0] == 0); bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    s  = a[31] ^ b[31];
    if (an || bn || (az && bz) || (ai && bi))  begin r = 32'h7FC00000;       x = 3'b100; end
    else if ((bz && !az) || (ai && !bi))       begin r = {s, 8'hFF, 23'd0};  x = 3'b010; end
    else if ((az && !bz) || (bi && !ai))       begin r = {s, 8'h00, 23'd0};  x = 3'b001; end
    else                                       begin r = sp_div(a, b);       x = 3'b000; end
`else
    r = sp_div(a, b);
    x = 3'b000;
`endif
  endtask

  // Bench stand-in for fp_division: registered inputs, registered quotient.
  always @(posedge clk) begin
    a1_0   <= div_a0;
    b1_0   <= div_b0;
    div_c0 <= sp_div(a1_0, b1_0);
    a1_1   <= div_a1;
    b1_1   <= div_b1;
    div_c1 <= sp_div(a1_1, b1_1);
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  task automatic mon_dut(input int d, input logic vld, input logic [7:0] bo, input logic dn, input logic [2:0] ex);
    logic [7:0] e;
    logic [2:0] ee;
    if (hold_vld[d]) begin
      check($sformatf("hold_vld%0d", d), 64'(vld), 64'd1);
      check($sformatf("hold_byte%0d", d), 64'(bo), 64'(hold_byte[d]));
    end
    hold_vld[d]  = vld && !byte_out_rdy;
    hold_byte[d] = bo;
    if (vld && byte_out_rdy) begin
      if ((d == 0 && q_exp0.size() == 0) || (d == 1 && q_exp1.size() == 0)) begin
        fail_now($sformatf("unexpected_byte%0d", d));
      end else begin
        if (d == 0) e = q_exp0.pop_front();
        else        e = q_exp1.pop_front();
        check($sformatf("byte_out%0d", d), 64'(bo), 64'(e));
      end
      nbytes[d]++;
    end
    if (dn) begin
      check($sformatf("done_vld_low%0d", d), 64'(vld), 64'd0);
      check($sformatf("done_nbytes%0d", d), 64'(nbytes[d]), 64'd4);
      nbytes[d] = 0;
      if ((d == 0 && q_exc0.size() == 0) || (d == 1 && q_exc1.size() == 0)) begin
        fail_now($sformatf("unexpected_done%0d", d));
      end else begin
        if (d == 0) ee = q_exc0.pop_front();
        else        ee = q_exc1.pop_front();
        check($sformatf("exc%0d", d), 64'(ex), 64'(ee));
      end
    end
  endtask

  // Backpressure is chosen first so the monitor sees the ready value that the next edge will use.
  always @(negedge clk) begin
    case (rdy_mode)
      0: byte_out_rdy = 1'b1;
      1: byte_out_rdy = ($urandom_range(0, 2) != 0);
      default: begin
        if (nbytes[0] == 1 && byte_out_vld0 && stall_cnt < 5) begin
          byte_out_rdy = 1'b0;
          stall_cnt++;
          check("stall_byte", 64'(byte_out0), 64'h40);
        end else begin
          byte_out_rdy = 1'b1;
        end
      end
    endcase
    if (rst_n) begin
      mon_dut(0, byte_out_vld0, byte_out0, done0, exc0);
      mon_dut(1, byte_out_vld1, byte_out1, done1, exc1);
    end
  end

  task automatic drive_byte(input logic [7:0] b0, input logic [7:0] b1, input bit gaps);
    int t;
    if (gaps && $urandom_range(0, 3) == 0) begin
      byte_vld = 1'b0;
      @(negedge clk);
    end
    byte_in0 = b0;
    byte_in1 = b1;
    byte_vld = 1'b1;
    t = 0;
    while (!byte_rdy0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!byte_rdy0) fail_now("byte_rdy_timeout");
    @(negedge clk);
    byte_vld = 1'b0;
  endtask

  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input bit gaps);
    logic [31:0] r, w;
    logic [2:0]  x;
    int          k;
    ref_div(a, b, r, x);
    for (int j = 0; j < 4; j++) begin
      q_exp0.push_back(r[8*(3-j) +: 8]);
      q_exp1.push_back(r[8*j +: 8]);
    end
    q_exc0.push_back(x);
    q_exc1.push_back(x);
    for (int i = 0; i < 8; i++) begin
      w = (i < 4) ? a : b;
      k = i % 4;
      drive_byte(w[8*(3-k) +: 8], w[8*k +: 8], gaps);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((q_exp0.size() != 0 || q_exp1.size() != 0 || q_exc0.size() != 0 || q_exc1.size() != 0
            || busy0 || busy1) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) fail_now("drain_timeout");
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] m;
    int          k;
    m = $urandom;
    k = $urandom_range(0, 11);
    case (k)
      0:       return {m[31], 31'd0};
      1:       return {m[31], 8'hFF, 23'd0};
      2:       return {m[31], 8'hFF, m[22:0] | 23'd1};
      3:       return {m[31], 8'h00, m[22:0]};
      default: return {m[31], 8'($urandom_range(100, 150)), m[22:0]};
    endcase
  endfunction

  initial begin
    for (int d = 0; d < 2; d++) begin
      nbytes[d]    = 0;
      hold_vld[d]  = 1'b0;
      hold_byte[d] = 8'h00;
    end
    rdy_mode     = 0;
    stall_cnt    = 0;
    rst_n        = 1'b0;
    byte_vld     = 1'b0;
    byte_in0     = 8'h00;
    byte_in1     = 8'h00;
    byte_out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    check("rst_byte_rdy0", 64'(byte_rdy0), 64'd1);
    check("rst_byte_rdy1", 64'(byte_rdy1), 64'd1);
    check("rst_out_vld", 64'(byte_out_vld0), 64'd0);
    check("rst_byte_out", 64'(byte_out0), 64'd0);
    check("rst_busy", 64'(busy0), 64'd0);
    check("rst_done", 64'(done0), 64'd0);
    check("rst_div_a", 64'(div_a0), 64'd0);
    check("rst_div_b", 64'(div_b0), 64'd0);
    check("rst_exc", 64'(exc0), 64'd0);

    // 6.0 / 2.0, then 1.0 / -4.0
    send_op(32'h40C00000, 32'h40000000, 1'b0);
    wait_idle();
    send_op(32'h3F800000, 32'hC0800000, 1'b0);
    wait_idle();

    // 6.0 / 2.0 with the second result byte held off for 5 cycles
    stall_cnt = 0;
    rdy_mode  = 2;
    send_op(32'h40C00000, 32'h40000000, 1'b0);
    wait_idle();
    check("stall_cycles", 64'(stall_cnt), 64'd5);
    rdy_mode = 0;

    // Reset after half a dividend discards it
    drive_byte(8'h11, 8'h22, 1'b0);
    drive_byte(8'h33, 8'h44, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_div_a", 64'(div_a0), 64'd0);
    check("midrst_byte_rdy", 64'(byte_rdy0), 64'd1);
    check("midrst_out_vld", 64'(byte_out_vld0), 64'd0);
    send_op(32'h3F800000, 32'hC0800000, 1'b0);
    wait_idle();
    check("reload_div_a0", 64'(div_a0), 64'h3F800000);
    check("reload_div_a1", 64'(div_a1), 64'h3F800000);
    check("reload_div_b1", 64'(div_b1), 64'hC0800000);

    // 1.0 / 0.0
    send_op(32'h3F800000, 32'h00000000, 1'b0);
    wait_idle();
    check("div0_exc0", 64'(exc0), 64'(EXC_DIV0));
    check("div0_exc1", 64'(exc1), 64'(EXC_DIV0));

    rdy_mode = 1;
    repeat (40) send_op(rnd_op(), rnd_op(), 1'b1);
    wait_idle();
    rdy_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
